// File: rtl/btb_pkg.sv
// Shared types and constants for the two-way branch target buffer.
// Direction counter encodings and the per-entry record layout.
package btb_pkg;

  typedef logic [1:0] btb_ctr_t;

  localparam btb_ctr_t CTR_SNT = 2'b00;
  localparam btb_ctr_t CTR_WNT = 2'b01;
  localparam btb_ctr_t CTR_WT  = 2'b10;
  localparam btb_ctr_t CTR_ST  = 2'b11;

  // Widest tag any legal configuration can store; narrower tags are zero-extended.
  localparam int unsigned TAG_MAX_W = 30;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    btb_ctr_t             ctr;
    logic [31:0]          target;
  } btb_entry_t;

endpackage

// File: rtl/btb_sat_ctr.sv
// Next-state function of the 2-bit saturating direction counter.
// Jumps force strongly-taken; branches step towards the resolved outcome.
module btb_sat_ctr
  import btb_pkg::*;
(
  input  btb_ctr_t ctr,
  input  logic     taken,
  input  logic     is_jump,
  output btb_ctr_t next_ctr
);

  // Saturating step, never wrapping between 00 and 11
  always_comb begin
    next_ctr = ctr;
    if (is_jump) begin
      next_ctr = CTR_ST;
    end else if (taken) begin
      if (ctr != CTR_ST) next_ctr = ctr + 2'd1;
      else               next_ctr = CTR_ST;
    end else begin
      if (ctr != CTR_SNT) next_ctr = ctr - 2'd1;
      else                next_ctr = CTR_SNT;
    end
  end

endmodule

// File: rtl/btb_2way.sv
// Two-way set-associative BTB: combinational lookup from the fetch PC,
// one registered update per cycle from EX, per-set LRU and whole-table flush.
module btb_2way
  import btb_pkg::*;
#(
  parameter int unsigned NUM_SETS = 64,
  parameter int unsigned TAG_W    = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] if_pc_i,
  output logic        pred_hit_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_taken_i,
  input  logic        ex_is_jump_i,
  input  logic        flush_i
);

  localparam int unsigned IDX_W = $clog2(NUM_SETS);

  // Control state is reset; tag/target payload is qualified by valid instead.
  logic [NUM_SETS-1:0] valid_r [2];
  btb_ctr_t            ctr_r   [2][NUM_SETS];
  logic [NUM_SETS-1:0] lru_r;
  logic [TAG_W-1:0]    tag_r    [2][NUM_SETS];
  logic [31:0]         target_r [2][NUM_SETS];

  logic [IDX_W-1:0] lk_idx_s, ex_idx_s;
  logic [TAG_W-1:0] lk_tag_s, ex_tag_s;
  btb_entry_t       lk_way_s [2];
  btb_entry_t       ex_way_s [2];
  logic [1:0]       lk_hit_s, ex_hit_s;
  logic             ex_any_hit_s, ex_hit_way_s, victim_s, wr_way_s;
  logic             upd_s, wr_hit_s, wr_alloc_s, wr_en_s, wr_target_s;
  btb_ctr_t         sat_in_s, sat_next_s, new_ctr_s;
  logic             unused_pc_s;

  assign lk_idx_s = if_pc_i[IDX_W+1:2];
  assign lk_tag_s = if_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_idx_s = ex_pc_i[IDX_W+1:2];
  assign ex_tag_s = ex_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc_s = ^{if_pc_i, ex_pc_i};

  // Gather both ways of the lookup set and the update set
  always_comb begin
    for (int w = 0; w < 2; w++) begin
      lk_way_s[w].valid  = valid_r[w][lk_idx_s];
      lk_way_s[w].tag    = TAG_MAX_W'(tag_r[w][lk_idx_s]);
      lk_way_s[w].ctr    = ctr_r[w][lk_idx_s];
      lk_way_s[w].target = target_r[w][lk_idx_s];
      lk_hit_s[w] = lk_way_s[w].valid && (lk_way_s[w].tag == TAG_MAX_W'(lk_tag_s));
      ex_way_s[w].valid  = valid_r[w][ex_idx_s];
      ex_way_s[w].tag    = TAG_MAX_W'(tag_r[w][ex_idx_s]);
      ex_way_s[w].ctr    = ctr_r[w][ex_idx_s];
      ex_way_s[w].target = target_r[w][ex_idx_s];
      ex_hit_s[w] = ex_way_s[w].valid && (ex_way_s[w].tag == TAG_MAX_W'(ex_tag_s));
    end
  end

  // Prediction outputs, zero unless a way hits
  always_comb begin
    pred_hit_o    = 1'b0;
    pred_taken_o  = 1'b0;
    pred_target_o = 32'h0000_0000;
    if (lk_hit_s[0]) begin
      pred_hit_o    = 1'b1;
      pred_taken_o  = lk_way_s[0].ctr[1];
      pred_target_o = lk_way_s[0].target;
    end else if (lk_hit_s[1]) begin
      pred_hit_o    = 1'b1;
      pred_taken_o  = lk_way_s[1].ctr[1];
      pred_target_o = lk_way_s[1].target;
    end else begin
      pred_hit_o    = 1'b0;
    end
  end

  assign ex_any_hit_s = |ex_hit_s;
  // At most one way hits, so way 1's hit bit names the hitting way.
  assign ex_hit_way_s = ex_hit_s[1];

  // Victim: first invalid way, way 0 first, else the LRU way
  always_comb begin
    victim_s = lru_r[ex_idx_s];
    if (!ex_way_s[0].valid) begin
      victim_s = 1'b0;
    end else if (!ex_way_s[1].valid) begin
      victim_s = 1'b1;
    end else begin
      victim_s = lru_r[ex_idx_s];
    end
  end

  assign upd_s       = ex_valid_i && !flush_i;
  assign wr_hit_s    = upd_s && ex_any_hit_s;
  assign wr_alloc_s  = upd_s && !ex_any_hit_s && ex_taken_i;
  assign wr_en_s     = wr_hit_s || wr_alloc_s;
  assign wr_way_s    = ex_any_hit_s ? ex_hit_way_s : victim_s;
  assign wr_target_s = wr_alloc_s || (wr_hit_s && (ex_taken_i || ex_is_jump_i));
  assign sat_in_s    = ex_way_s[ex_hit_way_s].ctr;

  btb_sat_ctr u_sat_ctr (
    .ctr      (sat_in_s),
    .taken    (ex_taken_i),
    .is_jump  (ex_is_jump_i),
    .next_ctr (sat_next_s)
  );

  assign new_ctr_s = ex_any_hit_s ? sat_next_s : (ex_is_jump_i ? CTR_ST : CTR_WT);

  // Valid, counter and LRU state with async reset and flush
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r[0] <= '0;
      valid_r[1] <= '0;
      lru_r      <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        ctr_r[0][s] <= CTR_SNT;
        ctr_r[1][s] <= CTR_SNT;
      end
    end else if (flush_i) begin
      valid_r[0] <= '0;
      valid_r[1] <= '0;
      lru_r      <= '0;
    end else if (wr_en_s) begin
      valid_r[wr_way_s][ex_idx_s] <= 1'b1;
      ctr_r[wr_way_s][ex_idx_s]   <= new_ctr_s;
      lru_r[ex_idx_s]             <= ~wr_way_s;
    end
  end

  // Tag and target payload, unreset
  always_ff @(posedge clk_i) begin
    if (wr_alloc_s) tag_r[wr_way_s][ex_idx_s] <= ex_tag_s;
    if (wr_target_s) target_r[wr_way_s][ex_idx_s] <= ex_target_i;
  end

endmodule
